column_prefetch_buffer: RTL and testbench
=========================================

Name: column_prefetch_buffer

Overview:
Sits between the angle generator and the WS2812 strip controller, in place of a direct texture-ROM lookup. On each new angle it prefetches one full texture column (LED_COUNT pixels) from the synchronous texture ROM into the back half of a ping-pong buffer. It swaps banks only at a strip-frame boundary, so every frame shifted out to the strip shows a single, consistent column with no mid-frame tearing.

Parameters:
LED_COUNT, 52, pixels per strip / rows per texture column
TEX_WIDTH, 256, texture columns (power of two)
THETA_BITS, 6, angle index width
PX_BITS, 6, strip pixel index width
DATA_WIDTH, 24, GRB pixel width
ADDR_WIDTH, $clog2(TEX_WIDTH*LED_COUNT) = 14, texture ROM address width

Ports:
clk  in  1  system clock; the block's only clock
reset  in  1  synchronous, active-high reset
theta  in  THETA_BITS  current angle index
px_num  in  PX_BITS  pixel index requested by the strip controller (next_px_num)
rom_addr  out  ADDR_WIDTH  texture ROM address; ROM returns data exactly 1 cycle later
rom_data  in  DATA_WIDTH  texture ROM read data
pixel  out  DATA_WIDTH  colour for px_num, registered
col_valid  out  1  front bank holds a complete column
busy  out  1  fetch in progress

Behaviour:
- Column mapping: col = (theta * TEX_WIDTH) >> THETA_BITS. Compute the product at THETA_BITS+log2(TEX_WIDTH) bits with no truncation before the shift.
- ROM address: rom_addr = idx*TEX_WIDTH + col, where idx runs 0..LED_COUNT-1.
- FSM states and transitions:
  - IDLE: if there is no fetched column yet, or theta differs from fetched_theta, latch col and fetched_theta, set idx=0 and go to FETCH.
  - FETCH: issue one rom_addr per cycle and increment idx. A 1-cycle delayed write-valid writes rom_data into back[idx_d]. When the write for idx_d = LED_COUNT-1 completes, go to READY. A fetch is LED_COUNT+1 cycles (53 by default). Changes on theta during FETCH are ignored.
  - READY: wait for a frame boundary.
    - On a boundary: toggle the bank, set col_valid=1, go to IDLE.
    - Else, if theta differs from fetched_theta: discard the back bank and go to IDLE, which refetches immediately (latest angle wins).
- Frame boundary: px_num_q == LED_COUNT-1 and px_num == 0, where px_num_q is px_num registered.
- Boundary and theta change in the same cycle while in READY: the swap wins. The theta change is picked up in IDLE on the next cycle.
- A boundary outside READY causes no swap; the front bank and col_valid are unchanged.
- busy = 1 in FETCH, 0 otherwise.
- pixel: registered one cycle after px_num.
  - Equals front[px_num] when col_valid=1 and px_num < LED_COUNT.
  - Otherwise 0, which covers px_num 52..63.
- rom_addr holds its last value outside FETCH.
- Reset values, applied on the cycle reset is sampled high: state=IDLE, bank=0, col_valid=0, busy=0, pixel=0, rom_addr=0, px_num_q=0, idx=0, have_column=0.
- Reset mid-FETCH aborts the fetch and discards partial data. Buffer contents are not cleared; they are masked by col_valid=0.
- Fetch restarts the first cycle after reset deasserts, because have_column=0.

Decomposition:
- Shared package/header holomap_pkg holds:
  - LED_COUNT, TEX_WIDTH, THETA_BITS, DATA_WIDTH and the derived ADDR_WIDTH, also used by the top-level mapper;
  - FSM state encodings IDLE/FETCH/READY.
- Sub-module pingpong_column_buffer contains the 2×LED_COUNT×DATA_WIDTH storage, with:
  - a write port on the back bank (we, waddr, wdata);
  - a registered read port on the front bank (raddr, rdata);
  - a bank-select toggle input.
- The FSM, address generation and boundary detection stay in column_prefetch_buffer.

Test Plan:
The ROM model returns rom_data = address from the previous cycle.
1. Reset, then hold theta=0 → busy high for 53 cycles, then low, with col_valid=0. Drive px_num 51→0 → col_valid=1. Then px_num=5 → pixel=1280 one cycle later.
2. theta=16 (col=64), complete fetch and boundary, px_num=3 → pixel=832; rom_addr sequence during fetch is 64, 320, …, 13120.
3. theta 16→17 at fetch cycle 20 → fetch completes col 64, READY sees the mismatch, refetches col 68 before any boundary. After the boundary, px_num=0 → pixel=68.
4. In READY, boundary and theta change in the same cycle → front switches to the old column (col_valid=1), then busy rises the next cycle for the new column.
5. Reset asserted at fetch cycle 20 → next cycle busy=0, col_valid=0, pixel=0. After deassert, the fetch restarts from idx 0.
6. theta=63 → col=252, last rom_addr=13308. px_num=52 and 63 → pixel=0.

Source files
------------

// File: rtl/column_prefetch_buffer_pkg.sv
// column_prefetch_buffer_pkg: shared geometry constants and FSM state encoding
package column_prefetch_buffer_pkg;
  localparam int LED_COUNT  = 52;
  localparam int TEX_WIDTH  = 256;
  localparam int THETA_BITS = 6;
  localparam int PX_BITS    = 6;
  localparam int DATA_WIDTH = 24;
  localparam int ADDR_WIDTH = $clog2(TEX_WIDTH * LED_COUNT);
  localparam int COL_BITS   = $clog2(TEX_WIDTH);
  localparam int IDX_BITS   = $clog2(LED_COUNT);
  typedef enum logic [1:0] {IDLE, FETCH, READY} state_t;
endpackage

// File: rtl/column_prefetch_buffer_if.sv
// column_prefetch_buffer_if: angle/strip/ROM signals of the column prefetch buffer
interface column_prefetch_buffer_if;
  import column_prefetch_buffer_pkg::*;
  logic [THETA_BITS-1:0] theta;
  logic [PX_BITS-1:0]    px_num;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_data;
  logic [DATA_WIDTH-1:0] pixel;
  logic                  col_valid;
  logic                  busy;
  modport master (output theta, px_num, rom_data, input rom_addr, pixel, col_valid, busy);
  modport slave  (input theta, px_num, rom_data, output rom_addr, pixel, col_valid, busy);
endinterface

// File: rtl/column_prefetch_buffer_pingpong.sv
// column_prefetch_buffer_pingpong: two-bank column store, write back bank, registered read of front bank
module column_prefetch_buffer_pingpong
  import column_prefetch_buffer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_toggle,
  input  logic                  i_we,
  input  logic [IDX_BITS-1:0]   i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [PX_BITS-1:0]    i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  logic [DATA_WIDTH-1:0] r_mem [2][LED_COUNT];
  logic                  r_bank;
  logic [DATA_WIDTH-1:0] r_rdata;
  // front bank selector; the other bank is the one being filled
  always_ff @(posedge clk) r_bank <= rst ? 1'b0 : r_bank ^ i_toggle;
  // storage is never cleared; out-of-range reads keep the old value and are masked upstream
  always_ff @(posedge clk) begin
    if (i_we) r_mem[~r_bank][i_waddr] <= i_wdata;
    if (i_raddr < PX_BITS'(LED_COUNT)) r_rdata <= r_mem[r_bank][i_raddr];
  end
  assign o_rdata = r_rdata;
endmodule

// File: rtl/column_prefetch_buffer.sv
// column_prefetch_buffer: prefetch one texture column per angle, swap banks only at strip frame boundaries
module column_prefetch_buffer
  import column_prefetch_buffer_pkg::*;
(
  input logic                     clk,
  input logic                     reset,
  column_prefetch_buffer_if.slave bus
);
  localparam logic [IDX_BITS-1:0] LAST = IDX_BITS'(LED_COUNT - 1);
  state_t                          r_state, w_next;
  logic [COL_BITS-1:0]             r_col;
  logic [THETA_BITS-1:0]           r_ftheta;
  logic [IDX_BITS-1:0]             r_idx, r_idx_d;
  logic                            r_we, r_issued, r_have, r_col_valid, r_pmask;
  logic [PX_BITS-1:0]              r_pxq;
  logic [THETA_BITS+COL_BITS-1:0]  w_prod;
  logic [COL_BITS-1:0]             w_col;
  logic [DATA_WIDTH-1:0]           w_rdata;
  logic                            w_change, w_start, w_wdone, w_boundary, w_swap, w_busy;
  assign w_prod     = (THETA_BITS+COL_BITS)'(bus.theta) * (THETA_BITS+COL_BITS)'(TEX_WIDTH);
  assign w_col      = COL_BITS'(w_prod >> THETA_BITS);
  assign w_change   = bus.theta != r_ftheta;
  assign w_start    = !r_have || w_change;
  assign w_wdone    = r_we && r_idx_d == LAST;
  assign w_boundary = r_pxq == PX_BITS'(LED_COUNT - 1) && bus.px_num == '0;
  assign w_swap     = r_state == READY && w_boundary;
  // state register
  always_ff @(posedge clk) r_state <= reset ? IDLE : w_next;
  // next state: a boundary in READY wins over a theta change, which is then seen from IDLE
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && w_start) w_next = FETCH;
    if (r_state == FETCH && w_wdone) w_next = READY;
    if (r_state == READY && (w_boundary || w_change)) w_next = IDLE;
    w_busy = r_state == FETCH;
  end
  // address generation, delayed write strobe, column status and pixel masking
  always_ff @(posedge clk) begin
    if (reset) begin
      r_col       <= '0;
      r_ftheta    <= '0;
      r_idx       <= '0;
      r_idx_d     <= '0;
      r_we        <= 1'b0;
      r_issued    <= 1'b0;
      r_have      <= 1'b0;
      r_col_valid <= 1'b0;
      r_pmask     <= 1'b0;
      r_pxq       <= '0;
    end else begin
      r_pxq   <= bus.px_num;
      r_pmask <= r_col_valid && bus.px_num < PX_BITS'(LED_COUNT);
      r_we    <= 1'b0;
      if (r_state == IDLE && w_start) begin
        r_col    <= w_col;
        r_ftheta <= bus.theta;
        r_idx    <= '0;
        r_issued <= 1'b0;
      end
      if (r_state == FETCH && !r_issued) begin
        r_we     <= 1'b1;
        r_idx_d  <= r_idx;
        r_issued <= r_idx == LAST;
        r_idx    <= r_idx == LAST ? r_idx : r_idx + 1'b1;
      end
      if (w_wdone) r_have <= 1'b1;
      if (w_swap) r_col_valid <= 1'b1;
    end
  end
  column_prefetch_buffer_pingpong u_buf (
    .clk     (clk),
    .rst     (reset),
    .i_toggle(w_swap),
    .i_we    (r_we),
    .i_waddr (r_idx_d),
    .i_wdata (bus.rom_data),
    .i_raddr (bus.px_num),
    .o_rdata (w_rdata)
  );
  assign bus.rom_addr  = ADDR_WIDTH'(r_idx) * ADDR_WIDTH'(TEX_WIDTH) + ADDR_WIDTH'(r_col);
  assign bus.pixel     = r_pmask ? w_rdata : '0;
  assign bus.col_valid = r_col_valid;
  assign bus.busy      = w_busy;
endmodule

// File: tb/tb_column_prefetch_buffer.sv
// tb_column_prefetch_buffer: directed and randomized checks against a column/pixel reference model
module tb_column_prefetch_buffer;
  import column_prefetch_buffer_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  int cycles;
  int cur_th;
  int addr_q[$];
  column_prefetch_buffer_if bus();
  column_prefetch_buffer dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) bus.rom_data <= DATA_WIDTH'(bus.rom_addr);
  function automatic int col_of(int th);
    return (th * TEX_WIDTH) >> THETA_BITS;
  endfunction
  function automatic int exp_px(int p, int th);
    return p < LED_COUNT ? p * TEX_WIDTH + col_of(th) : 0;
  endfunction
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_fetch(input int chg_at, input int new_th);
    addr_q.delete();
    cycles = 0;
    for (int i = 0; i < 10 && !bus.busy; i++) tick();
    if (!bus.busy) begin
      check("busy_rise", 0, 1);
      return;
    end
    while (bus.busy && cycles < 200) begin
      addr_q.push_back(int'(bus.rom_addr));
      if (cycles == chg_at) bus.theta = THETA_BITS'(new_th);
      cycles++;
      tick();
    end
  endtask
  task automatic boundary;
    bus.px_num = PX_BITS'(LED_COUNT - 1);
    tick();
    bus.px_num = '0;
    tick();
  endtask
  task automatic read_px(input string tag, input int p, input int exp);
    bus.px_num = PX_BITS'(p);
    tick();
    check(tag, int'(bus.pixel), exp);
  endtask
  initial begin
    bus.theta = '0;
    bus.px_num = '0;
    tick();
    tick();
    check("rst_busy", int'(bus.busy), 0);
    check("rst_col_valid", int'(bus.col_valid), 0);
    check("rst_pixel", int'(bus.pixel), 0);
    check("rst_rom_addr", int'(bus.rom_addr), 0);
    reset = 1'b0;
    wait_fetch(-1, 0);
    check("t1_cycles", cycles, LED_COUNT + 1);
    check("t1_col_valid_pre", int'(bus.col_valid), 0);
    boundary();
    check("t1_col_valid", int'(bus.col_valid), 1);
    read_px("t1_px5", 5, 1280);
    bus.theta = 6'd16;
    wait_fetch(-1, 0);
    check("t2_cycles", cycles, LED_COUNT + 1);
    check("t2_addr0", addr_q[0], 64);
    check("t2_addr1", addr_q[1], 320);
    check("t2_addr51", addr_q[51], 13120);
    read_px("t2_old_front", 4, exp_px(4, 0));
    boundary();
    read_px("t2_px3", 3, 832);
    bus.theta = 6'd63;
    wait_fetch(-1, 0);
    check("t6_addr51", addr_q[51], 13308);
    check("t6_addr_hold", int'(bus.rom_addr), 13308);
    boundary();
    read_px("t6_px52", 52, 0);
    read_px("t6_px63", 63, 0);
    read_px("t6_px51", 51, exp_px(51, 63));
    bus.theta = 6'd16;
    wait_fetch(20, 17);
    check("t3_cycles", cycles, LED_COUNT + 1);
    check("t3_addr51", addr_q[51], 13120);
    wait_fetch(-1, 0);
    check("t3_refetch_cycles", cycles, LED_COUNT + 1);
    check("t3_refetch_addr0", addr_q[0], 68);
    read_px("t3_front_kept", 10, exp_px(10, 63));
    check("t3_col_valid", int'(bus.col_valid), 1);
    boundary();
    read_px("t3_px0", 0, 68);
    bus.theta = 6'd40;
    wait_fetch(-1, 0);
    bus.px_num = PX_BITS'(LED_COUNT - 1);
    tick();
    bus.px_num = '0;
    bus.theta = 6'd41;
    tick();
    check("t4_col_valid", int'(bus.col_valid), 1);
    check("t4_busy_low", int'(bus.busy), 0);
    read_px("t4_swapped_px7", 7, exp_px(7, 40));
    check("t4_busy_next", int'(bus.busy), 1);
    wait_fetch(-1, 0);
    read_px("t4_still_old", 7, exp_px(7, 40));
    boundary();
    read_px("t4_new_px7", 7, exp_px(7, 41));
    bus.theta = 6'd50;
    for (int i = 0; i < 10 && !bus.busy; i++) tick();
    repeat (20) tick();
    reset = 1'b1;
    tick();
    check("t5_busy", int'(bus.busy), 0);
    check("t5_col_valid", int'(bus.col_valid), 0);
    check("t5_pixel", int'(bus.pixel), 0);
    reset = 1'b0;
    wait_fetch(-1, 0);
    check("t5_cycles", cycles, LED_COUNT + 1);
    check("t5_addr0", addr_q[0], 200);
    boundary();
    read_px("t5_px2", 2, exp_px(2, 50));
    cur_th = 50;
    for (int r = 0; r < 8; r++) begin
      int th, k;
      th = (cur_th + 1 + int'($urandom_range(0, 62))) % 64;
      bus.theta = THETA_BITS'(th);
      wait_fetch(-1, 0);
      check("rnd_cycles", cycles, LED_COUNT + 1);
      k = int'($urandom_range(0, LED_COUNT - 1));
      check("rnd_addr", addr_q[k], k * TEX_WIDTH + col_of(th));
      boundary();
      check("rnd_col_valid", int'(bus.col_valid), 1);
      for (int j = 0; j < 3; j++) begin
        int p;
        p = int'($urandom_range(0, 63));
        read_px("rnd_pixel", p, exp_px(p, th));
      end
      cur_th = th;
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
